// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one 32-bit UART word transmitter
// Grants one requester at a time, latches its word, runs one transfer and acks or aborts on watchdog.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_data,
  input  logic [N_REQ-1:0]     req_one_byte,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     err,
  output logic                 busy,
  output logic                 tx_send_start,
  output logic [31:0]          tx_data,
  output logic                 tx_one_byte,
  input  logic                 tx_data_end
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_ABORT
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [31:0]        data_q, data_d;
  logic               ob_q, ob_d;

  logic [IDX_W-1:0]   pick;
  logic               pick_valid;

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin : pick_search
    int               idx;
    logic [IDX_W-1:0] cand;
    idx        = 0;
    cand       = '0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IDX_W'(idx);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    wd_d    = wd_q;
    ack_d   = '0;
    err_d   = '0;
    start_d = 1'b0;
    data_d  = data_q;
    ob_d    = ob_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          win_d   = pick;
          start_d = 1'b1;
          state_d = S_START;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
              data_d = req_data[32*i +: 32];
              ob_d   = req_one_byte[i];
            end
          end
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wd_q != WD_W'(TIMEOUT_CYCLES)) wd_d = wd_q + 1'b1;
        // Completion wins over a watchdog expiring in the same cycle.
        if (tx_data_end) begin
          ack_d[win_q] = 1'b1;
          state_d      = S_DONE;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          err_d[win_q] = 1'b1;
          state_d      = S_ABORT;
        end
      end
      S_DONE, S_ABORT: begin
        rr_d    = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= IDX_W'(N_REQ - 1);
      win_q   <= '0;
      wd_q    <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      ob_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      wd_q    <= wd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      data_q  <= data_d;
      ob_q    <= ob_d;
    end
  end

  assign ack           = ack_q;
  assign err           = err_q;
  assign busy          = busy_q;
  assign tx_send_start = start_q;
  assign tx_data       = data_q;
  assign tx_one_byte   = ob_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed table-driven bench for uart_tx_arbiter
// Bench plays the UART word transmitter by returning tx_data_end after a per-vector delay.
module tb_uart_tx_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   req_one_byte;
  logic [3:0]   ack;
  logic [3:0]   err;
  logic         busy;
  logic         tx_send_start;
  logic [31:0]  tx_data;
  logic         tx_one_byte;
  logic         tx_data_end;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(100)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .req_one_byte  (req_one_byte),
    .ack           (ack),
    .err           (err),
    .busy          (busy),
    .tx_send_start (tx_send_start),
    .tx_data       (tx_data),
    .tx_one_byte   (tx_one_byte),
    .tx_data_end   (tx_data_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   req;
    logic [3:0]   ob;
    logic [127:0] data;
    int           delay;
    logic [3:0]   exp_ack;
    logic [31:0]  exp_data;
    logic         exp_ob;
  } vec_t;

  localparam logic [127:0] DW = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge with the arbiter idle.
  task automatic run_xfer(input vec_t v, input string tag);
    req          = v.req;
    req_one_byte = v.ob;
    req_data     = v.data;
    @(negedge clk);
    chk({tag, "_start"}, {31'd0, tx_send_start}, 32'd1);
    chk({tag, "_data"}, tx_data, v.exp_data);
    chk({tag, "_ob"}, {31'd0, tx_one_byte}, {31'd0, v.exp_ob});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i <= v.delay; i++) begin
      @(negedge clk);
      if (i == 0) chk({tag, "_start_pulse"}, {31'd0, tx_send_start}, 32'd0);
    end
    tx_data_end = 1'b1;
    @(negedge clk);
    tx_data_end = 1'b0;
    chk({tag, "_ack"}, {28'd0, ack}, {28'd0, v.exp_ack});
    chk({tag, "_noerr"}, {28'd0, err}, 32'd0);
    chk({tag, "_held"}, tx_data, v.exp_data);
    req = 4'b0000;
    @(negedge clk);
    chk({tag, "_ack_off"}, {28'd0, ack}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin : stim
    int   n;
    logic seen_ack;
    vec_t v;

    vecs[0] = '{4'b1111, 4'b1010, DW, 3, 4'b0001, 32'hA0A0A0A0, 1'b0};
    vecs[1] = '{4'b1111, 4'b1010, DW, 0, 4'b0010, 32'hB1B1B1B1, 1'b1};
    vecs[2] = '{4'b1111, 4'b1010, DW, 5, 4'b0100, 32'hC2C2C2C2, 1'b0};
    vecs[3] = '{4'b1111, 4'b1010, DW, 1, 4'b1000, 32'hD3D3D3D3, 1'b1};
    vecs[4] = '{4'b1111, 4'b1010, DW, 2, 4'b0001, 32'hA0A0A0A0, 1'b0};
    vecs[5] = '{4'b0001, 4'b0000, {96'd0, 32'hDEADBEEF}, 6, 4'b0001, 32'hDEADBEEF, 1'b0};
    vecs[6] = '{4'b0100, 4'b0100, {32'd0, 32'h00000041, 64'd0}, 2, 4'b0100, 32'h00000041, 1'b1};
    vecs[7] = '{4'b1001, 4'b0001, DW, 1, 4'b1000, 32'hD3D3D3D3, 1'b0};
    vecs[8] = '{4'b1001, 4'b0001, DW, 4, 4'b0001, 32'hA0A0A0A0, 1'b1};
    vecs[9] = '{4'b0110, 4'b0000, DW, 0, 4'b0010, 32'hB1B1B1B1, 1'b0};

    reset        = 1'b1;
    req          = 4'b0000;
    req_data     = '0;
    req_one_byte = 4'b0000;
    tx_data_end  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_err", {28'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, tx_send_start}, 32'd0);
    chk("rst_data", tx_data, 32'd0);
    chk("rst_ob", {31'd0, tx_one_byte}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_xfer(vecs[i], $sformatf("v%0d", i));

    // Completion pulse while idle must not produce an ack.
    tx_data_end = 1'b1;
    @(negedge clk);
    tx_data_end = 1'b0;
    chk("idle_end_ack", {28'd0, ack}, 32'd0);
    chk("idle_end_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("idle_end_ack2", {28'd0, ack}, 32'd0);

    // Word latched at grant; later data change, req drop and an early end pulse are ignored.
    req      = 4'b0010;
    req_data = {64'd0, 32'hCAFEF00D, 32'd0};
    @(negedge clk);
    chk("t6_start", {31'd0, tx_send_start}, 32'd1);
    req_data    = '0;
    tx_data_end = 1'b1;
    @(negedge clk);
    tx_data_end = 1'b0;
    req         = 4'b0000;
    chk("t6_data", tx_data, 32'hCAFEF00D);
    chk("t6_early_end", {28'd0, ack}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    tx_data_end = 1'b1;
    @(negedge clk);
    tx_data_end = 1'b0;
    chk("t6_ack", {28'd0, ack}, 32'h2);
    @(negedge clk);

    // Back-to-back: requester 1 waiting is granted in the idle cycle right after done.
    req      = 4'b0011;
    req_data = DW;
    @(negedge clk);
    chk("bb_start0", {31'd0, tx_send_start}, 32'd1);
    chk("bb_data0", tx_data, 32'hA0A0A0A0);
    repeat (2) @(negedge clk);
    tx_data_end = 1'b1;
    @(negedge clk);
    tx_data_end = 1'b0;
    chk("bb_ack0", {28'd0, ack}, 32'h1);
    req = 4'b0010;
    @(negedge clk);
    chk("bb_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("bb_start1", {31'd0, tx_send_start}, 32'd1);
    chk("bb_data1", tx_data, 32'hB1B1B1B1);
    @(negedge clk);
    tx_data_end = 1'b1;
    @(negedge clk);
    tx_data_end = 1'b0;
    chk("bb_ack1", {28'd0, ack}, 32'h2);
    req = 4'b0000;
    @(negedge clk);

    // Watchdog abort with no completion pulse.
    req      = 4'b0001;
    req_data = {96'd0, 32'h12345678};
    @(negedge clk);
    chk("t4_start", {31'd0, tx_send_start}, 32'd1);
    n        = 0;
    seen_ack = 1'b0;
    while (n < 150 && err === 4'b0000) begin
      @(negedge clk);
      n++;
      if (ack !== 4'b0000) seen_ack = 1'b1;
    end
    chk("t4_err", {28'd0, err}, 32'h1);
    chk("t4_err_lat_ok", {31'd0, (n >= 100 && n <= 101)}, 32'd1);
    chk("t4_no_ack", {31'd0, seen_ack}, 32'd0);
    req = 4'b0000;
    @(negedge clk);
    chk("t4_err_off", {28'd0, err}, 32'd0);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    v = '{4'b0010, 4'b0000, DW, 1, 4'b0010, 32'hB1B1B1B1, 1'b0};
    run_xfer(v, "t4_next");

    // Reset in the middle of a transfer.
    req      = 4'b0100;
    req_data = DW;
    @(negedge clk);
    chk("t5_start", {31'd0, tx_send_start}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_data", tx_data, 32'd0);
    chk("t5_ob", {31'd0, tx_one_byte}, 32'd0);
    chk("t5_start_off", {31'd0, tx_send_start}, 32'd0);
    reset    = 1'b0;
    req      = 4'b0000;
    seen_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack !== 4'b0000 || err !== 4'b0000) seen_ack = 1'b1;
    end
    chk("t5_no_ack_err", {31'd0, seen_ack}, 32'd0);
    v = '{4'b1111, 4'b0000, DW, 2, 4'b0001, 32'hA0A0A0A0, 1'b0};
    run_xfer(v, "t5_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
